// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg
// Shared types and constants for the instruction fetch path.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

    typedef logic [31:0] regval_t;

    // Canonical no-op (addi x0, x0, 0); shown on the decode side when nothing is fetched.
    localparam regval_t Nop       = 32'h0000_0013;
    localparam regval_t ADDR_STEP = 32'd4;

    typedef struct packed {
        regval_t instruction;
        regval_t pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo
// Synchronous FIFO of fetch entries. Clear has priority over push.
// The head is presented as Nop/pc=0 whenever the queue is empty.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output logic [CW-1:0] count_o,
    output logic         valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          w_do_pop;
    logic          w_do_push;

    // Next-state for pointers and occupancy; a pop frees the slot a same-cycle push may use.
    always_comb begin
        w_do_pop  = pop_i && (count_q != '0);
        w_do_push = push_i && ((count_q != CW'(DEPTH)) || w_do_pop);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (w_do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            count_d = count_q + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through a non-zero count, so no reset.
    always_ff @(posedge clock_i) begin
        if (!clear_i && w_do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Head view: Nop with pc 0 while empty.
    always_comb begin
        count_o = count_q;
        valid_o = (count_q != '0);
        head_o  = valid_o ? mem_q[rd_ptr_q] : {Nop, 32'h0};
    end

`ifndef SYNTHESIS
    // A push into a full queue without a matching pop means the credit logic was violated.
    always_ff @(posedge clock_i) begin
        if (reset_n_i && !clear_i && push_i && !w_do_pop) begin
            assert (count_q != CW'(DEPTH));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// prefetch_unit
// In-order instruction prefetcher: issues up to MAX_OUTSTANDING reads, queues
// returned words with their PCs, and drops stale responses after a redirect.
// Revision: 1.0 - initial release
// ============================================================================
module prefetch_unit
    import core_pkg::*;
#(
    parameter regval_t RESET_PC        = 32'h0,
    parameter int      DEPTH           = 4,
    parameter int      MAX_OUTSTANDING = 2
) (
    input  logic    clock_i,
    input  logic    reset_n_i,
    input  logic    redirect_valid_i,
    input  regval_t redirect_pc_i,
    output logic    address_enable_o,
    output regval_t address_o,
    input  logic    address_ready_i,
    input  logic    data_valid_i,
    input  regval_t data_i,
    input  logic    hold_i,
    output logic    out_valid_o,
    output regval_t out_instruction_o,
    output regval_t out_pc_o
);

    localparam int CW = $clog2(DEPTH + 1);

    regval_t       fetch_pc_q, fetch_pc_d;
    regval_t       resp_pc_q, resp_pc_d;
    // outstanding counts every read still owed by memory, stale ones included;
    // discard is the subset of those that must be thrown away.
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_occupancy;
    logic          w_credit, w_issue, w_accept, w_pop;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    // Issue credit, request handshake and response/pop qualification.
    always_comb begin
        w_occupancy      = {1'b0, w_fifo_count} + {1'b0, outstanding_q};
        w_credit         = (outstanding_q < CW'(MAX_OUTSTANDING))
                        && (w_occupancy < (CW+1)'(DEPTH));
        address_enable_o = reset_n_i && !redirect_valid_i && w_credit;
        address_o        = fetch_pc_q;
        w_issue          = address_enable_o && address_ready_i;
        w_accept         = data_valid_i && !redirect_valid_i && (discard_q == '0);
        w_pop            = out_valid_o && !hold_i && !redirect_valid_i;
        w_push_entry     = {data_i, resp_pc_q};
    end

    // Next-state for PCs and in-flight counters; redirect marks every surviving read stale.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(w_issue) - CW'(data_valid_i);
        discard_d     = discard_q;
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            discard_d  = outstanding_q - CW'(data_valid_i);
        end else begin
            if (w_issue)  fetch_pc_d = fetch_pc_q + ADDR_STEP;
            if (w_accept) resp_pc_d  = resp_pc_q + ADDR_STEP;
            if (data_valid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clock_i      (clock_i),
        .reset_n_i    (reset_n_i),
        .clear_i      (redirect_valid_i),
        .push_i       (w_accept),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .count_o      (w_fifo_count),
        .valid_o      (out_valid_o),
        .head_o       (w_head)
    );

    // Decode-facing view of the queue head.
    always_comb begin
        out_instruction_o = w_head.instruction;
        out_pc_o          = w_head.pc;
    end

endmodule
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// ============================================================================
// tb_prefetch_unit
// Scoreboard bench: a behavioural memory with per-request latency feeds the
// prefetcher; expected {instruction, pc} pairs are queued as responses land
// and compared against the queue head as decode pops them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prefetch_unit;
    import core_pkg::*;

    localparam int      DEPTH    = 4;
    localparam int      MAXO     = 2;
    localparam regval_t RESET_PC = 32'h0;

    logic    clock = 1'b0;
    logic    reset_n;
    logic    redirect_valid;
    regval_t redirect_pc;
    logic    address_enable;
    regval_t address;
    logic    address_ready;
    logic    data_valid;
    regval_t data;
    logic    hold;
    logic    out_valid;
    regval_t out_instruction;
    regval_t out_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        pend[$];
    logic [63:0] sb[$];
    logic [31:0] exp_fetch;
    int          cyc;
    int          last_due;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    prefetch_unit #(
        .RESET_PC        (RESET_PC),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clock_i           (clock),
        .reset_n_i         (reset_n),
        .redirect_valid_i  (redirect_valid),
        .redirect_pc_i     (redirect_pc),
        .address_enable_o  (address_enable),
        .address_o         (address),
        .address_ready_i   (address_ready),
        .data_valid_i      (data_valid),
        .data_i            (data),
        .hold_i            (hold),
        .out_valid_o       (out_valid),
        .out_instruction_o (out_instruction),
        .out_pc_o          (out_pc)
    );

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: called at a negedge, drives inputs, checks, updates model, advances.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit hld,
                        input bit rdy, input int lat);
        bit   dv;
        bit   exp_ae;
        req_t r;
        int   due;
        redirect_valid = redir;
        redirect_pc    = rpc;
        hold           = hld;
        address_ready  = rdy;
        dv             = (pend.size() != 0) && (pend[0].due <= cyc);
        data_valid     = dv;
        data           = dv ? memval(pend[0].addr) : $urandom;
        #1;
        check("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            check("out_pc", out_pc, sb[0][31:0]);
            check("out_instr", out_instruction, sb[0][63:32]);
        end
        exp_ae = !redir && (pend.size() < MAXO) && ((sb.size() + pend.size()) < DEPTH);
        check("addr_en", address_enable, exp_ae);
        if (exp_ae) check("address", address, exp_fetch);

        if (redir) begin
            sb.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            if (dv) void'(pend.pop_front());
            exp_fetch = rpc;
        end else begin
            if (sb.size() != 0 && !hld) void'(sb.pop_front());
            if (dv) begin
                r = pend.pop_front();
                if (!r.stale) sb.push_back({memval(r.addr), r.addr});
            end
            if (exp_ae && rdy) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: exp_fetch, due: due, stale: 1'b0});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        bit          found;
        logic [31:0] rnd;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        address_ready  = 1'b0;
        data_valid     = 1'b0;
        data           = '0;
        hold           = 1'b0;
        cyc            = 0;
        last_due       = -1;
        exp_fetch      = RESET_PC;
        repeat (3) @(posedge clock);
        @(negedge clock);
        address_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instruction, Nop);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_addr_en", address_enable, 0);
        check("rst_address", address, RESET_PC);
        reset_n = 1'b1;

        // Streaming with 1-cycle memory.
        repeat (12) step(0, 0, 0, 1, 1);

        // Sustained hold: queue fills, requests stop.
        repeat (10) step(0, 0, 1, 1, 1);
        #1;
        check("hold_addr_en_low", address_enable, 0);
        check("hold_out_valid", out_valid, 1);
        repeat (10) step(0, 0, 0, 1, 1);

        // 3-cycle memory, redirect with two reads in flight.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() == 2) found = 1;
            else step(0, 0, 0, 1, 3);
        end
        check("two_in_flight", found, 1);
        step(1, 32'h100, 0, 1, 3);
        repeat (16) step(0, 0, 0, 1, 3);

        // Redirect coinciding with a response while decode holds.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() != 0 && pend[0].due <= cyc) found = 1;
            else step(0, 0, 1, 1, 2);
        end
        check("dv_redirect_setup", found, 1);
        step(1, 32'h180, 1, 1, 2);
        #1;
        check("redir_dv_empty", out_valid, 0);
        repeat (12) step(0, 0, 0, 1, 2);

        // Back-to-back redirects: last one wins.
        step(1, 32'h200, 0, 1, 1);
        step(1, 32'h300, 0, 1, 1);
        repeat (12) step(0, 0, 0, 1, 1);

        // Address wrap past 0xFFFFFFFC.
        step(1, 32'hFFFF_FFF8, 0, 1, 1);
        repeat (12) step(0, 0, 0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rnd      = $urandom;
            rnd[1:0] = 2'b00;
            step(($urandom_range(0, 19) == 0), rnd, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
